knn_query_sched: RTL and testbench
==================================

Name: knn_query_sched

Overview:
- Round-robin scheduler that shares one KNN inference datapath among N_REQ query requesters. The datapath is the distance engine, the sorter and the k-nearest type voter.
- Grants one query at a time and pulses the distance/sort engine start.
- Hands the sorted result to the voter with a one-cycle valid_sort pulse, captures the voted type and returns it to the granted requester with its ID.
- Sits between the host/query interface and the KNN pipeline.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TYPE_W, 2, width of class/type label; must match the voter.
- TMO_CYC, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  N_REQ  per-requester query request.
- req_ready  out  N_REQ  one-hot grant/accept.
- dist_start  out  1  one-cycle start pulse to distance/sort engine.
- sort_done  in  1  sorter result valid (level or pulse).
- valid_sort  out  1  one-cycle pulse to voter.
- inference_done  in  1  voter done pulse.
- inferred_type  in  TYPE_W  voter result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  $clog2(N_REQ)  requester index of response.
- rsp_type  out  TYPE_W  returned type.
- rsp_err  out  1  response is a timeout error.
- busy  out  1  high in any state other than IDLE.
- query_cnt  out  16  completed responses; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = N_REQ-1, so requester 0 wins first; watchdog = 0.
- Reset mid-operation aborts everything to IDLE next cycle. No response is produced for the aborted query. Downstream blocks share rst.
- States: IDLE -> START -> WAIT_SORT -> VOTE -> WAIT_INFER -> RESP -> IDLE.
- IDLE
  - req_ready is combinational: one-hot bit for the first asserted req_valid searching from (last_grant+1) mod N_REQ upward with wrap. It is all-zero when no request is pending or state != IDLE.
  - On handshake: latch index into cur_id, update last_grant, go START.
- START: dist_start=1 for exactly one cycle -> WAIT_SORT.
- WAIT_SORT: on sort_done=1 -> VOTE. sort_done is ignored in every other state.
- VOTE: valid_sort=1 for exactly one cycle -> WAIT_INFER.
- WAIT_INFER: on inference_done=1 -> RESP. In the same edge: rsp_type<=inferred_type, rsp_id<=cur_id, rsp_err<=0. inference_done is ignored outside WAIT_INFER.
- RESP
  - rsp_valid held high; rsp_id, rsp_type and rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, query_cnt<=query_cnt+1, -> IDLE.
  - A new grant can occur no earlier than the cycle after return to IDLE.
- Minimum latency from grant edge to rsp_valid: 4 cycles plus sorter and voter latency. Sorter latency 0 means sort_done is already high on entry to WAIT_SORT.
- Requests that are not granted stay pending. req_valid may drop without penalty before grant. No requester is starved: a pending requester is granted within N_REQ queries.

Optional Feature:
- Macro KNN_QUERY_SCHED_TIMEOUT_EN.
- When defined:
  - Watchdog counter clears on entry to WAIT_SORT and on entry to WAIT_INFER, and increments each cycle in those states.
  - On reaching TMO_CYC-1 without the awaited input: go to RESP with rsp_err=1, rsp_type=0, rsp_id=cur_id.
  - The timeout response also increments query_cnt when accepted.
- When undefined: no counter logic; rsp_err is tied 0; WAIT states wait indefinitely.

Test Plan:
- Single request: req_valid=4'b0001, sort_done 10 cycles after dist_start, inference_done with inferred_type=2'd3 7 cycles after valid_sort -> one dist_start pulse, one valid_sort pulse, rsp_valid with rsp_id=0, rsp_type=3, rsp_err=0; query_cnt=1 after accept.
- Round-robin fairness: req_valid=4'b1111 held for 8 queries -> grant order 0,1,2,3,0,1,2,3.
- Back-pressure: rsp_ready low 20 cycles in RESP -> rsp_valid and outputs stable; no new req_ready until 1 cycle after accept.
- Spurious inputs: pulse sort_done in IDLE and inference_done in WAIT_SORT -> no state change, no valid_sort.
- Reset mid-query: assert rst during WAIT_INFER -> next cycle IDLE, busy=0, all outputs 0, last_grant reset; the pending requester 0 is granted again first.
- With KNN_QUERY_SCHED_TIMEOUT_EN, TMO_CYC=16: withhold sort_done -> rsp_valid with rsp_err=1, rsp_type=0 after 16 cycles in WAIT_SORT; query_cnt increments on accept.

Source files
------------

// File: rtl/knn_query_sched_if.sv
// Host-side query request / typed response bus of the KNN query scheduler.
// The scheduler drives the slave modport; the query host uses master.
interface knn_query_sched_if #(
   parameter int N_REQ  = 4,
   parameter int TYPE_W = 2
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]  req_valid;
   logic [N_REQ-1:0]  req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [TYPE_W-1:0] rsp_type;
   logic              rsp_err;

   modport master (
      output req_valid, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_type, rsp_err
   );

   modport slave (
      input  req_valid, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_type, rsp_err
   );
endinterface

// File: rtl/knn_query_sched.sv
// Round-robin scheduler sharing one distance/sort/vote KNN datapath among N_REQ requesters.
// Define KNN_QUERY_SCHED_TIMEOUT_EN to add a watchdog that answers stalled queries with rsp_err.
module knn_query_sched #(
   parameter int N_REQ   = 4,
   parameter int TYPE_W  = 2,
   parameter int TMO_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst,
   knn_query_sched_if.slave  host_if,
   output logic              dist_start_o,
   input  logic              sort_done_i,
   output logic              valid_sort_o,
   input  logic              inference_done_i,
   input  logic [TYPE_W-1:0] inferred_type_i,
   output logic              busy_o,
   output logic [15:0]       query_cnt_o
);
   localparam int ID_W = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_SORT,
      S_VOTE,
      S_WAIT_INFER,
      S_RESP
   } state_e;

   state_e            state_q;
   logic [ID_W-1:0]   last_grant_q;
   logic [ID_W-1:0]   cur_id_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic [TYPE_W-1:0] rsp_type_q;
   logic              dist_start_q;
   logic              valid_sort_q;
   logic              rsp_valid_q;
   logic [15:0]       query_cnt_q;
   logic [15:0]       query_cnt_d;

   logic [N_REQ-1:0]  grant_d;
   logic [ID_W-1:0]   grant_idx_d;
   logic              grant_any_d;
   logic [ID_W-1:0]   scan_idx;

`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TMO_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);
   logic [WD_W-1:0]   wd_q;
   logic              rsp_err_q;
`endif

   // Search starts just past the previous winner so every pending requester gets a turn.
   always_comb begin
      grant_d     = '0;
      grant_idx_d = '0;
      grant_any_d = 1'b0;
      scan_idx    = '0;
      if (state_q == S_IDLE) begin
         for (int i = 1; i <= N_REQ; i++) begin
            scan_idx = ID_W'((int'(last_grant_q) + i) % N_REQ);
            if (!grant_any_d && host_if.req_valid[scan_idx]) begin
               grant_any_d       = 1'b1;
               grant_idx_d       = scan_idx;
               grant_d[scan_idx] = 1'b1;
            end
         end
      end
   end

   assign query_cnt_d = query_cnt_q + 16'd1;

   // Sequence one query through the shared pipeline, then hold the result until taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_W'(N_REQ - 1);
         cur_id_q     <= '0;
         rsp_id_q     <= '0;
         rsp_type_q   <= '0;
         dist_start_q <= 1'b0;
         valid_sort_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         query_cnt_q  <= '0;
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
         wd_q         <= '0;
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         dist_start_q <= 1'b0;
         valid_sort_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_any_d) begin
                  cur_id_q     <= grant_idx_d;
                  last_grant_q <= grant_idx_d;
                  dist_start_q <= 1'b1;
                  state_q      <= S_START;
               end
            end
            S_START: begin
               state_q <= S_WAIT_SORT;
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
               wd_q    <= '0;
`endif
            end
            S_WAIT_SORT: begin
               if (sort_done_i) begin
                  valid_sort_q <= 1'b1;
                  state_q      <= S_VOTE;
               end
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
               else if (wd_q == WD_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_type_q  <= '0;
                  rsp_id_q    <= cur_id_q;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
`endif
            end
            S_VOTE: begin
               state_q <= S_WAIT_INFER;
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
               wd_q    <= '0;
`endif
            end
            S_WAIT_INFER: begin
               if (inference_done_i) begin
                  rsp_valid_q <= 1'b1;
                  rsp_type_q  <= inferred_type_i;
                  rsp_id_q    <= cur_id_q;
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
                  state_q     <= S_RESP;
               end
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
               else if (wd_q == WD_LAST) begin
                  rsp_valid_q <= 1'b1;
                  rsp_type_q  <= '0;
                  rsp_id_q    <= cur_id_q;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
`endif
            end
            S_RESP: begin
               if (host_if.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  query_cnt_q <= query_cnt_d;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign host_if.req_ready = grant_d;
   assign host_if.rsp_valid = rsp_valid_q;
   assign host_if.rsp_id    = rsp_id_q;
   assign host_if.rsp_type  = rsp_type_q;
`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
   assign host_if.rsp_err   = rsp_err_q;
`else
   assign host_if.rsp_err   = 1'b0;
`endif
   assign dist_start_o = dist_start_q;
   assign valid_sort_o = valid_sort_q;
   assign busy_o       = (state_q != S_IDLE);
   assign query_cnt_o  = query_cnt_q;
endmodule

// File: tb/tb_knn_query_sched.sv
// Scoreboard bench for knn_query_sched: directed queries push expected grants/responses, a monitor pops them.
// The timeout scenario runs only when KNN_QUERY_SCHED_TIMEOUT_EN is defined (TMO_CYC = 16 here).
module tb_knn_query_sched;
   localparam int N_REQ   = 4;
   localparam int TYPE_W  = 2;
   localparam int TMO_CYC = 16;

   typedef struct packed {
      logic [1:0] id;
      logic [1:0] typ;
      logic       err;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dist_start;
   logic        sort_done;
   logic        valid_sort;
   logic        inference_done;
   logic [1:0]  inferred_type;
   logic        busy;
   logic [15:0] query_cnt;

   knn_query_sched_if #(.N_REQ(N_REQ), .TYPE_W(TYPE_W)) hif ();

   knn_query_sched #(.N_REQ(N_REQ), .TYPE_W(TYPE_W), .TMO_CYC(TMO_CYC)) dut (
      .clk              (clk),
      .rst              (rst),
      .host_if          (hif),
      .dist_start_o     (dist_start),
      .sort_done_i      (sort_done),
      .valid_sort_o     (valid_sort),
      .inference_done_i (inference_done),
      .inferred_type_i  (inferred_type),
      .busy_o           (busy),
      .query_cnt_o      (query_cnt)
   );

   always #5 clk = ~clk;

   int nChecks = 0;
   int nFail   = 0;
   int distCnt = 0;
   int vsCnt   = 0;
   rsp_t       expRsp[$];
   logic [1:0] expGrant[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic rsp_t mkRsp(input logic [1:0] id, input logic [1:0] typ, input logic err);
      rsp_t r;
      r.id  = id;
      r.typ = typ;
      r.err = err;
      return r;
   endfunction

   // Monitor: counts pulses and checks every grant and accepted response against the queues.
   always @(negedge clk) begin
      rsp_t e;
      if (!rst) begin
         if (dist_start) distCnt++;
         if (valid_sort) vsCnt++;
         if (|hif.req_ready) begin
            if (expGrant.size() == 0) checkOutput("unexpected grant", 32'(hif.req_ready), 32'd0);
            else checkOutput("grant", 32'(hif.req_ready), 32'd1 << expGrant.pop_front());
         end
         if (hif.rsp_valid && hif.rsp_ready) begin
            if (expRsp.size() == 0) checkOutput("unexpected rsp", 32'(expRsp.size()), 32'd1);
            else begin
               e = expRsp.pop_front();
               checkOutput("rsp_id", 32'(hif.rsp_id), 32'(e.id));
               checkOutput("rsp_type", 32'(hif.rsp_type), 32'(e.typ));
               checkOutput("rsp_err", 32'(hif.rsp_err), 32'(e.err));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sigSel(input int sel);
      case (sel)
         0:       return dist_start;
         1:       return valid_sort;
         2:       return hif.rsp_valid;
         default: return !busy;
      endcase
   endfunction

   task automatic waitFor(input int sel, input string name);
      int n = 0;
      while (!sigSel(sel) && n < 200) begin
         tick();
         n++;
      end
      checkOutput({"wait ", name}, 32'(sigSel(sel)), 32'd1);
   endtask

   // Play the downstream engine for one granted query; returns with the response presented.
   task automatic applyStimulus(input logic [3:0] validAfter, input int sortLat, input int inferLat,
                                input logic [1:0] typ, input bit spurious);
      int vs0;
      waitFor(0, "dist_start");
      hif.req_valid = validAfter;
      vs0 = vsCnt;
      for (int i = 0; i < sortLat; i++) begin
         tick();
         inference_done = spurious && (i == 0);
      end
      inference_done = 1'b0;
      if (spurious) begin
         checkOutput("spurious infer no valid_sort", 32'(vsCnt - vs0), 32'd0);
         checkOutput("spurious infer still busy", 32'(busy), 32'd1);
         checkOutput("spurious infer no rsp", 32'(hif.rsp_valid), 32'd0);
      end
      sort_done = 1'b1;
      tick();
      sort_done = 1'b0;
      waitFor(1, "valid_sort");
      repeat (inferLat) tick();
      inferred_type  = typ;
      inference_done = 1'b1;
      tick();
      inference_done = 1'b0;
      waitFor(2, "rsp_valid");
   endtask

   task automatic resetDut();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL global timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      int d0, v0, n, bad;
      rst = 1'b1;
      hif.req_valid  = '0;
      hif.rsp_ready  = 1'b1;
      sort_done      = 1'b0;
      inference_done = 1'b0;
      inferred_type  = '0;
      repeat (3) tick();

      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst dist_start", 32'(dist_start), 32'd0);
      checkOutput("rst valid_sort", 32'(valid_sort), 32'd0);
      checkOutput("rst rsp_valid", 32'(hif.rsp_valid), 32'd0);
      checkOutput("rst rsp_id", 32'(hif.rsp_id), 32'd0);
      checkOutput("rst rsp_type", 32'(hif.rsp_type), 32'd0);
      checkOutput("rst rsp_err", 32'(hif.rsp_err), 32'd0);
      checkOutput("rst query_cnt", 32'(query_cnt), 32'd0);
      checkOutput("rst req_ready", 32'(hif.req_ready), 32'd0);
      rst = 1'b0;
      tick();

      $display("[TB] single request");
      expGrant.push_back(2'd0);
      expRsp.push_back(mkRsp(2'd0, 2'd3, 1'b0));
      d0 = distCnt;
      v0 = vsCnt;
      hif.req_valid = 4'b0001;
      applyStimulus(4'b0000, 10, 7, 2'd3, 1'b0);
      checkOutput("single rsp_id held", 32'(hif.rsp_id), 32'd0);
      checkOutput("single rsp_type held", 32'(hif.rsp_type), 32'd3);
      waitFor(3, "idle");
      checkOutput("single dist pulses", 32'(distCnt - d0), 32'd1);
      checkOutput("single valid_sort pulses", 32'(vsCnt - v0), 32'd1);
      checkOutput("single query_cnt", 32'(query_cnt), 32'd1);

      $display("[TB] round-robin fairness");
      resetDut();
      for (int i = 0; i < 8; i++) begin
         expGrant.push_back(2'(i % 4));
         expRsp.push_back(mkRsp(2'(i % 4), 2'((i + 1) % 4), 1'b0));
      end
      d0 = distCnt;
      hif.req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         applyStimulus((i == 7) ? 4'b0000 : 4'b1111, 3, 2, 2'((i + 1) % 4), 1'b0);
         waitFor(3, "idle");
      end
      checkOutput("fair query_cnt", 32'(query_cnt), 32'd8);
      checkOutput("fair dist pulses", 32'(distCnt - d0), 32'd8);

      $display("[TB] minimum latency");
      expGrant.push_back(2'd1);
      expRsp.push_back(mkRsp(2'd1, 2'd2, 1'b0));
      sort_done      = 1'b1;
      inference_done = 1'b1;
      inferred_type  = 2'd2;
      hif.req_valid  = 4'b0010;
      tick();
      hif.req_valid = 4'b0000;
      n = 0;
      while (!hif.rsp_valid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("min latency", 32'(n), 32'd4);
      sort_done      = 1'b0;
      inference_done = 1'b0;
      waitFor(3, "idle");
      checkOutput("latency query_cnt", 32'(query_cnt), 32'd9);

      $display("[TB] spurious inputs");
      d0 = distCnt;
      v0 = vsCnt;
      sort_done = 1'b1;
      tick();
      sort_done      = 1'b0;
      inference_done = 1'b1;
      tick();
      inference_done = 1'b0;
      tick();
      checkOutput("idle spurious busy", 32'(busy), 32'd0);
      checkOutput("idle spurious valid_sort", 32'(vsCnt - v0), 32'd0);
      checkOutput("idle spurious dist_start", 32'(distCnt - d0), 32'd0);
      expGrant.push_back(2'd2);
      expRsp.push_back(mkRsp(2'd2, 2'd1, 1'b0));
      hif.req_valid = 4'b0100;
      applyStimulus(4'b0000, 4, 3, 2'd1, 1'b1);
      waitFor(3, "idle");
      checkOutput("spurious query_cnt", 32'(query_cnt), 32'd10);

      $display("[TB] back-pressure");
      expGrant.push_back(2'd0);
      expRsp.push_back(mkRsp(2'd0, 2'd2, 1'b0));
      expGrant.push_back(2'd3);
      expRsp.push_back(mkRsp(2'd3, 2'd0, 1'b0));
      hif.rsp_ready = 1'b0;
      hif.req_valid = 4'b0001;
      applyStimulus(4'b1000, 2, 2, 2'd2, 1'b0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (hif.rsp_valid !== 1'b1 || hif.rsp_id !== 2'd0 || hif.rsp_type !== 2'd2 ||
             hif.rsp_err !== 1'b0 || hif.req_ready !== 4'b0000) bad++;
      end
      checkOutput("bp outputs stable", 32'(bad), 32'd0);
      checkOutput("bp query_cnt held", 32'(query_cnt), 32'd10);
      hif.rsp_ready = 1'b1;
      checkOutput("bp no grant before accept", 32'(hif.req_ready), 32'd0);
      tick();
      checkOutput("bp rsp_valid dropped", 32'(hif.rsp_valid), 32'd0);
      checkOutput("bp grant after accept", 32'(hif.req_ready), 32'b1000);
      checkOutput("bp query_cnt", 32'(query_cnt), 32'd11);
      applyStimulus(4'b0000, 2, 2, 2'd0, 1'b0);
      waitFor(3, "idle");
      checkOutput("bp second query_cnt", 32'(query_cnt), 32'd12);

      $display("[TB] reset mid-query");
      expGrant.push_back(2'd0);
      hif.req_valid = 4'b0001;
      waitFor(0, "dist_start");
      hif.req_valid = 4'b0011;
      tick();
      sort_done = 1'b1;
      tick();
      sort_done = 1'b0;
      waitFor(1, "valid_sort");
      tick();
      tick();
      checkOutput("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      checkOutput("mid rst busy", 32'(busy), 32'd0);
      checkOutput("mid rst rsp_valid", 32'(hif.rsp_valid), 32'd0);
      checkOutput("mid rst query_cnt", 32'(query_cnt), 32'd0);
      checkOutput("mid rst dist_start", 32'(dist_start), 32'd0);
      checkOutput("mid rst valid_sort", 32'(valid_sort), 32'd0);
      expGrant.push_back(2'd0);
      expRsp.push_back(mkRsp(2'd0, 2'd1, 1'b0));
      expGrant.push_back(2'd1);
      expRsp.push_back(mkRsp(2'd1, 2'd3, 1'b0));
      rst = 1'b0;
      checkOutput("post rst grant req 0", 32'(hif.req_ready), 32'b0001);
      applyStimulus(4'b0010, 2, 2, 2'd1, 1'b0);
      waitFor(3, "idle");
      applyStimulus(4'b0000, 2, 2, 2'd3, 1'b0);
      waitFor(3, "idle");
      checkOutput("post rst query_cnt", 32'(query_cnt), 32'd2);

`ifdef KNN_QUERY_SCHED_TIMEOUT_EN
      $display("[TB] sort timeout");
      expGrant.push_back(2'd0);
      expRsp.push_back(mkRsp(2'd0, 2'd0, 1'b1));
      hif.rsp_ready = 1'b0;
      hif.req_valid = 4'b0001;
      waitFor(0, "dist_start");
      hif.req_valid = 4'b0000;
      tick();
      n = 0;
      while (!hif.rsp_valid && n < 100) begin
         n++;
         tick();
      end
      checkOutput("timeout cycles in WAIT_SORT", 32'(n), 32'd16);
      checkOutput("timeout rsp_err", 32'(hif.rsp_err), 32'd1);
      checkOutput("timeout rsp_type", 32'(hif.rsp_type), 32'd0);
      hif.rsp_ready = 1'b1;
      waitFor(3, "idle");
      checkOutput("timeout query_cnt", 32'(query_cnt), 32'd3);
`endif

      tick();
      checkOutput("grant queue drained", 32'(expGrant.size()), 32'd0);
      checkOutput("rsp queue drained", 32'(expRsp.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
